fetch_decode_queue: RTL

- Parametrised fetch-to-decode pipeline buffer. It replaces the single-entry fetch/decode latch with a DEPTH-entry FIFO that uses a valid/ready handshake.
- Carries PC, instruction word and fetch exception info per entry. Supports two flush classes and a decode-side stall.
- Sits between the fetch stage (I-cache/PC generation) and the decoder, decoupling fetch bubbles from decode stalls.

---
 rtl/fetch_decode_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode FIFO with valid/ready handshake, two flush classes and decode stall.
// Optional same-cycle bypass when empty: define FETCH_DECODE_QUEUE_BYPASS_EN.
module fetch_decode_queue #(
  parameter int unsigned ADDR_W  = 40,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned CAUSE_W = 64,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FLUSH_P1,
  input  logic                         FLUSH_P2,
  input  logic                         LOCK_PIPELINE,
  input  logic                         FETCH_VALID,
  output logic                         FETCH_READY,
  input  logic [ADDR_W-1:0]            PC_FROM_FETCH,
  input  logic [INST_W-1:0]            INST_FROM_FETCH,
  input  logic                         FETCH_XCPT,
  input  logic [CAUSE_W-1:0]           FETCH_XCPT_CAUSE,
  output logic                         DEC_VALID,
  output logic [ADDR_W-1:0]            PC_TO_DECODE,
  output logic [INST_W-1:0]            INST_TO_DECODE,
  output logic                         DEC_XCPT,
  output logic [CAUSE_W-1:0]           DEC_XCPT_CAUSE,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INST_W-1:0]  inst_mem  [DEPTH];
  logic               xcpt_mem  [DEPTH];
  logic [CAUSE_W-1:0] cause_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;

  logic               head_valid, flush_now, push, pop, byp_used, wr_en, rd_en;
  logic [INST_W-1:0]  st_inst;
  logic [CAUSE_W-1:0] st_cause;

  always_comb begin
    st_inst  = FETCH_XCPT ? '0 : INST_FROM_FETCH;
    st_cause = FETCH_XCPT ? FETCH_XCPT_CAUSE : '0;
  end

  assign head_valid  = (count_q != '0);
  assign FETCH_READY = (count_q < CNT_W'(DEPTH));
  // Lock outranks FLUSH_P2, so a P2 flush only takes effect when unlocked.
  assign flush_now   = FLUSH_P1 | (FLUSH_P2 & ~LOCK_PIPELINE);
  assign push        = FETCH_VALID & FETCH_READY;
  assign pop         = DEC_VALID & ~LOCK_PIPELINE;
  assign COUNT       = count_q;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = ~head_valid & FETCH_VALID;
  assign DEC_VALID = ~flush_now & (head_valid | bypass);
  assign byp_used  = bypass & pop;

  always_comb begin
    PC_TO_DECODE   = '0;
    INST_TO_DECODE = '0;
    DEC_XCPT       = 1'b0;
    DEC_XCPT_CAUSE = '0;
    if (DEC_VALID && head_valid) begin
      PC_TO_DECODE   = pc_mem[rd_ptr];
      INST_TO_DECODE = inst_mem[rd_ptr];
      DEC_XCPT       = xcpt_mem[rd_ptr];
      DEC_XCPT_CAUSE = cause_mem[rd_ptr];
    end else if (DEC_VALID) begin
      PC_TO_DECODE   = PC_FROM_FETCH;
      INST_TO_DECODE = st_inst;
      DEC_XCPT       = FETCH_XCPT;
      DEC_XCPT_CAUSE = st_cause;
    end
  end
`else
  assign DEC_VALID = head_valid;
  assign byp_used  = 1'b0;

  always_comb begin
    PC_TO_DECODE   = '0;
    INST_TO_DECODE = '0;
    DEC_XCPT       = 1'b0;
    DEC_XCPT_CAUSE = '0;
    if (head_valid) begin
      PC_TO_DECODE   = pc_mem[rd_ptr];
      INST_TO_DECODE = inst_mem[rd_ptr];
      DEC_XCPT       = xcpt_mem[rd_ptr];
      DEC_XCPT_CAUSE = cause_mem[rd_ptr];
    end
  end
`endif

  // A bypassed entry that decode consumes never touches storage or pointers.
  assign wr_en = push & ~byp_used;
  assign rd_en = pop & ~byp_used;

  always_ff @(posedge CLK) begin
    if (wr_en && !flush_now) begin
      pc_mem[wr_ptr]    <= PC_FROM_FETCH;
      inst_mem[wr_ptr]  <= st_inst;
      xcpt_mem[wr_ptr]  <= FETCH_XCPT;
      cause_mem[wr_ptr] <= st_cause;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush_now) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
